// File: rtl/beam_buffer_sched.sv
// rtl/beam_buffer_sched.sv - write/read sequencer for the 4-block beam buffer
module beam_buffer_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int BLK_LEN    = 1584,
  parameter int NUM_BLK    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sop,
  input  logic                  i_din_vld,
  output logic                  o_rvalid,
  output logic                  o_wr_wen,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [1:0]            o_blk_idx,
  output logic                  o_rd_ren,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_busy,
  output logic                  o_frame_done,
  output logic                  o_err_short,
  output logic                  o_err_ovf
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BLK_LEN - 1);
  localparam logic [1:0]            LAST_BLK  = 2'(NUM_BLK - 1);
  // Dead cycles between the last buffer write and the first read, covering
  // the buffer write pipeline and RAM read latency.
  localparam logic [2:0]            RD_WAIT   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_READ
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_wr_cnt;
  logic [1:0]              r_blk_idx;
  logic [2:0]              r_wait;
  logic [ADDR_WIDTH-1:0]   r_rd_cnt;
  logic                    r_rd_last;

  logic                    w_start;
  logic                    w_wr_go;
  logic                    w_restart;
  logic                    w_wr_last;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;

  assign w_start = i_sop & i_din_vld;

  // Decide whether this cycle writes a sample, where it lands, and whether it closes the block
  always_comb begin
    w_wr_go   = 1'b0;
    w_restart = 1'b0;
    w_wr_addr = r_wr_cnt;
    case (r_state)
      S_IDLE, S_GAP: begin
        w_wr_go   = w_start;
        w_wr_addr = '0;
      end
      S_WRITE: begin
        w_wr_go = i_din_vld;
        if (w_start) begin
          // A new start inside a partly written block restarts that block
          w_wr_addr = '0;
          w_restart = (r_wr_cnt != '0);
        end
      end
      default: begin
        w_wr_go = 1'b0;
      end
    endcase
    w_wr_last = w_wr_go && (w_wr_addr == LAST_ADDR);
  end

  // Sequencer FSM with registered write/read strobes, addresses and sticky error flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_wr_cnt     <= '0;
      r_blk_idx    <= '0;
      r_wait       <= '0;
      r_rd_cnt     <= '0;
      r_rd_last    <= 1'b0;
      o_rvalid     <= 1'b0;
      o_wr_wen     <= 1'b0;
      o_wr_addr    <= '0;
      o_blk_idx    <= '0;
      o_rd_ren     <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_busy    <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_short  <= 1'b0;
      o_err_ovf    <= 1'b0;
    end else begin
      o_wr_wen     <= 1'b0;
      o_rd_ren     <= 1'b0;
      o_frame_done <= 1'b0;

      if (w_wr_go) begin
        o_wr_wen  <= 1'b1;
        o_wr_addr <= w_wr_addr;
        o_blk_idx <= r_blk_idx;
        o_rvalid  <= 1'b1;
        if (w_restart) begin
          o_err_short <= 1'b1;
        end
        if (w_wr_last) begin
          r_wr_cnt <= '0;
          if (r_blk_idx == LAST_BLK) begin
            r_blk_idx <= '0;
            r_state   <= S_READ;
            r_wait    <= '0;
            r_rd_cnt  <= '0;
            r_rd_last <= 1'b0;
            o_rd_busy <= 1'b1;
          end else begin
            r_blk_idx <= r_blk_idx + 2'd1;
            r_state   <= S_GAP;
          end
        end else begin
          r_wr_cnt <= w_wr_addr + 1'b1;
          r_state  <= S_WRITE;
        end
      end else begin
        case (r_state)
          S_IDLE, S_GAP: begin
            // Burst window closes the cycle after the block's final write
            o_rvalid <= 1'b0;
          end
          S_WRITE: begin
            // Bubble inside a burst: window stays open, counter holds
            o_rvalid <= 1'b1;
          end
          S_READ: begin
            o_rvalid <= 1'b0;
            // Bursts arriving mid-sweep are dropped; only IDLE accepts a new start
            if (w_start) begin
              o_err_ovf <= 1'b1;
            end
            if (r_rd_last) begin
              o_frame_done <= 1'b1;
              o_rd_busy    <= 1'b0;
              r_state      <= S_IDLE;
            end else if (r_wait != RD_WAIT) begin
              r_wait <= r_wait + 3'd1;
            end else begin
              o_rd_ren  <= 1'b1;
              o_rd_addr <= r_rd_cnt;
              if (r_rd_cnt == LAST_ADDR) begin
                r_rd_last <= 1'b1;
              end else begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beam_buffer_sched.sv
// tb/tb_beam_buffer_sched.sv - self-checking bench for beam_buffer_sched
module tb_beam_buffer_sched;

  localparam int BL  = 1584;
  localparam int SBL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: full-size instance, index 1: BLK_LEN=8 / ADDR_WIDTH=3 instance
  logic       rst    [2];
  logic       sop    [2];
  logic       vld    [2];
  logic       wen    [2];
  logic       rvalid [2];
  logic       ren    [2];
  logic       busy   [2];
  logic       fdone  [2];
  logic       eshort [2];
  logic       eovf   [2];
  logic [1:0] blk    [2];
  logic [10:0] waddr [2];
  logic [10:0] raddr [2];
  logic [10:0] b_waddr, b_raddr;
  logic [2:0]  s_waddr, s_raddr;

  assign waddr[0] = b_waddr;
  assign raddr[0] = b_raddr;
  assign waddr[1] = {8'b0, s_waddr};
  assign raddr[1] = {8'b0, s_raddr};

  beam_buffer_sched #(.ADDR_WIDTH(11), .BLK_LEN(BL), .NUM_BLK(4)) dut (
    .i_clk(clk), .i_reset(rst[0]), .i_sop(sop[0]), .i_din_vld(vld[0]),
    .o_rvalid(rvalid[0]), .o_wr_wen(wen[0]), .o_wr_addr(b_waddr), .o_blk_idx(blk[0]),
    .o_rd_ren(ren[0]), .o_rd_addr(b_raddr), .o_rd_busy(busy[0]), .o_frame_done(fdone[0]),
    .o_err_short(eshort[0]), .o_err_ovf(eovf[0])
  );

  beam_buffer_sched #(.ADDR_WIDTH(3), .BLK_LEN(SBL), .NUM_BLK(4)) dut_s (
    .i_clk(clk), .i_reset(rst[1]), .i_sop(sop[1]), .i_din_vld(vld[1]),
    .o_rvalid(rvalid[1]), .o_wr_wen(wen[1]), .o_wr_addr(s_waddr), .o_blk_idx(blk[1]),
    .o_rd_ren(ren[1]), .o_rd_addr(s_raddr), .o_rd_busy(busy[1]), .o_frame_done(fdone[1]),
    .o_err_short(eshort[1]), .o_err_ovf(eovf[1])
  );

  int total = 0;
  int bad   = 0;

  // scoreboards: writes encoded blk*4096+addr, reads as addr
  int wq[$];
  int rq[$];

  int falls     [2];
  int done_cnt  [2];
  int since_wen [2];
  logic prev_rv [2];
  logic prev_ren[2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    int e;
    for (int k = 0; k < 2; k++) begin
      if (wen[k] === 1'b1) begin
        chk("wen_expected", int'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("wr_addr", int'(waddr[k]), e % 4096);
          chk("wr_blk", int'(blk[k]), e / 4096);
        end
        chk("rvalid_with_wen", int'(rvalid[k]), 1);
      end
      if (ren[k] === 1'b1) begin
        if (prev_ren[k] !== 1'b1) chk("rd_dead_cycles", since_wen[k], 4);
        chk("ren_expected", int'(rq.size() != 0), 1);
        if (rq.size() != 0) chk("rd_addr", int'(raddr[k]), rq.pop_front());
        chk("busy_with_ren", int'(busy[k]), 1);
      end
      if (wen[k] === 1'b1) since_wen[k] = 0;
      else if (since_wen[k] < 100000) since_wen[k]++;
      if (prev_rv[k] === 1'b1 && rvalid[k] === 1'b0) falls[k]++;
      if (fdone[k] === 1'b1) done_cnt[k]++;
      prev_rv[k]  = rvalid[k];
      prev_ren[k] = ren[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int n);
    sop[k] = 1'b0;
    vld[k] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic burst(input int k, input int n, input int b, input bit bubble, input bit exp_wr);
    for (int i = 0; i < n; i++) begin
      sop[k] = (i == 0);
      vld[k] = 1'b1;
      if (exp_wr) wq.push_back(b * 4096 + i);
      tick();
      if (bubble) begin
        sop[k] = 1'b0;
        vld[k] = 1'b0;
        tick();
      end
    end
    sop[k] = 1'b0;
    vld[k] = 1'b0;
  endtask

  task automatic expect_read(input int len);
    for (int i = 0; i < len; i++) rq.push_back(i);
  endtask

  task automatic wait_done(input int k, input int budget);
    int start;
    int c;
    start = done_cnt[k];
    c = 0;
    while (done_cnt[k] == start && c < budget) begin
      tick();
      c++;
    end
    chk("frame_done_seen", int'(done_cnt[k] != start), 1);
  endtask

  function automatic int all_outs(input int k);
    return int'({wen[k], rvalid[k], ren[k], busy[k], fdone[k], eshort[k], eovf[k]}) +
           int'(waddr[k]) + int'(raddr[k]) + int'(blk[k]);
  endfunction

  typedef struct {
    int n;
    bit bubble;
    int gap;
    int blk;
    bit last;
    bit exp_short;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int f0;
    int d0;
    int cnt;

    // nominal frame, bubbled frame, short-burst frame on the full-size instance
    for (int b = 0; b < 4; b++) begin
      tbl[b]     = '{BL, 1'b0, 10, b, (b == 3), 1'b0};
      tbl[4 + b] = '{BL, 1'b1, 10, b, (b == 3), 1'b0};
    end
    tbl[8]  = '{BL,  1'b0, 10, 0, 1'b0, 1'b0};
    tbl[9]  = '{700, 1'b0, 0,  1, 1'b0, 1'b0};
    tbl[10] = '{BL,  1'b0, 10, 1, 1'b0, 1'b1};
    tbl[11] = '{BL,  1'b0, 10, 2, 1'b0, 1'b1};
    tbl[12] = '{BL,  1'b0, 10, 3, 1'b1, 1'b1};

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; sop[k] = 1'b0; vld[k] = 1'b0;
      falls[k] = 0; done_cnt[k] = 0; since_wen[k] = 100000;
      prev_rv[k] = 1'b0; prev_ren[k] = 1'b0;
    end
    repeat (3) tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("reset_outputs_big", all_outs(0), 0);
    chk("reset_outputs_small", all_outs(1), 0);
    tick();

    f0 = falls[0];
    d0 = done_cnt[0];
    for (int i = 0; i < 13; i++) begin
      burst(0, tbl[i].n, tbl[i].blk, tbl[i].bubble, 1'b1);
      if (tbl[i].last) begin
        expect_read(BL);
        wait_done(0, 3 * BL);
        idle(0, 5);
        chk("rvalid_falls_per_frame", falls[0] - f0, 4);
        chk("frame_done_once", done_cnt[0] - d0, 1);
        chk("busy_after_frame", int'(busy[0]), 0);
        chk("err_ovf_clear", int'(eovf[0]), 0);
        chk("wq_drained_frame", wq.size(), 0);
        chk("rq_drained_frame", rq.size(), 0);
        f0 = falls[0];
        d0 = done_cnt[0];
      end else begin
        idle(0, tbl[i].gap);
      end
      chk("err_short", int'(eshort[0]), int'(tbl[i].exp_short));
    end

    // overrun: a burst starting ~100 cycles into the read sweep is dropped
    for (int b = 0; b < 4; b++) begin
      burst(0, BL, b, 1'b0, 1'b1);
      if (b != 3) idle(0, 10);
    end
    expect_read(BL);
    idle(0, 99);
    burst(0, 50, 0, 1'b0, 1'b0);
    chk("err_ovf_set", int'(eovf[0]), 1);
    chk("busy_during_ovf", int'(busy[0]), 1);
    wait_done(0, 3 * BL);
    chk("rq_drained_ovf", rq.size(), 0);
    burst(0, BL, 0, 1'b0, 1'b1);
    idle(0, 10);
    burst(0, BL, 1, 1'b0, 1'b1);
    idle(0, 10);
    chk("err_ovf_sticky", int'(eovf[0]), 1);
    chk("err_short_sticky", int'(eshort[0]), 1);

    // reset at block 2, addr 500
    burst(0, 501, 2, 1'b0, 1'b1);
    rst[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_reset_outputs", all_outs(0), 0);
    chk("wq_drained_reset", wq.size(), 0);
    tick();
    rst[0] = 1'b0;
    burst(0, BL, 0, 1'b0, 1'b1);
    idle(0, 10);
    chk("post_reset_wq_drained", wq.size(), 0);
    chk("post_reset_flags", int'({eshort[0], eovf[0]}), 0);

    // small instance: one frame with gaps, then back-to-back frame with zero gaps
    f0 = falls[1];
    for (int b = 0; b < 4; b++) begin
      burst(1, SBL, b, 1'b0, 1'b1);
      if (b != 3) idle(1, 2);
    end
    expect_read(SBL);
    cnt = 0;
    while (fdone[1] !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("small_done_seen", int'(fdone[1]), 1);
    chk("small_falls", falls[1] - f0, 4);
    for (int b = 0; b < 4; b++) burst(1, SBL, b, 1'b0, 1'b1);
    expect_read(SBL);
    wait_done(1, 200);
    idle(1, 5);
    chk("small_done_count", done_cnt[1], 2);
    chk("small_flags", int'({eshort[1], eovf[1], busy[1]}), 0);

    chk("wq_drained_end", wq.size(), 0);
    chk("rq_drained_end", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
